// File: rtl/uart_rst_ack.sv
// Responder for the UART reset sequencer: checks CLK_RST/MOD_RST ordering and hold times, then raises READY after a settle window.
// Optional settle-completion counter output RST_CNT is enabled by defining UART_RST_ACK_STATS_EN.
module uart_rst_ack #(
    parameter int unsigned MIN_CLK_HOLD = 2,
    parameter int unsigned MIN_MOD_HOLD = 200,
    parameter int unsigned SETTLE_CYC   = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CLK_RST,
    input  logic       MOD_RST,
    output logic       READY,
    output logic       ERR,
    output logic [1:0] ERR_CODE,
`ifdef UART_RST_ACK_STATS_EN
    output logic [7:0] RST_CNT,
`endif
    output logic [2:0] STATE
);

    // state      | meaning
    // WAIT_RST   | idle after RST, waiting for the sequencer to assert resets
    // CLK_HOLD   | both resets high, timing the common hold
    // MOD_HOLD   | module reset high alone, timing its hold
    // SETTLE     | both released, waiting SETTLE_CYC before READY
    // READY      | UART released and settled
    // ERROR      | sticky protocol violation, left only by RST
    typedef enum logic [2:0] {
        S_WAIT_RST = 3'd0,
        S_CLK_HOLD = 3'd1,
        S_MOD_HOLD = 3'd2,
        S_SETTLE   = 3'd3,
        S_READY    = 3'd4,
        S_ERROR    = 3'd5
    } state_t;

    localparam logic [7:0] L_MIN_CLK = 8'(MIN_CLK_HOLD);
    localparam logic [7:0] L_MIN_MOD = 8'(MIN_MOD_HOLD);
    localparam logic [7:0] L_SETTLE  = 8'(SETTLE_CYC);

    localparam logic [1:0] L_ERR_ORPHAN = 2'd1;
    localparam logic [1:0] L_ERR_HOLD   = 2'd2;
    localparam logic [1:0] L_ERR_ORDER  = 2'd3;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_ready;
    logic       r_err;
    logic [1:0] r_err_code;

    state_t     w_nxt;
    logic       w_set_err;
    logic [1:0] w_code;
    logic [1:0] w_cm;

    assign w_cm = {CLK_RST, MOD_RST};

    always_comb begin
        w_nxt     = r_state;
        w_set_err = 1'b0;
        w_code    = 2'd0;
        case (r_state)
            S_WAIT_RST, S_SETTLE: begin
                case (w_cm)
                    2'b11: w_nxt = S_CLK_HOLD;
                    2'b10: begin
                        w_set_err = 1'b1;
                        w_code    = L_ERR_ORPHAN;
                    end
                    2'b01: w_nxt = S_MOD_HOLD;
                    default: begin
                        if (r_state == S_SETTLE && r_cnt == L_SETTLE) begin
                            w_nxt = S_READY;
                        end
                    end
                endcase
            end
            S_CLK_HOLD: begin
                if (!MOD_RST) begin
                    w_set_err = 1'b1;
                    w_code    = L_ERR_ORDER;
                end else if (!CLK_RST) begin
                    if (r_cnt >= L_MIN_CLK) begin
                        w_nxt = S_MOD_HOLD;
                    end else begin
                        w_set_err = 1'b1;
                        w_code    = L_ERR_HOLD;
                    end
                end
            end
            S_MOD_HOLD: begin
                case (w_cm)
                    2'b11: w_nxt = S_CLK_HOLD;
                    2'b10: begin
                        w_set_err = 1'b1;
                        w_code    = L_ERR_ORPHAN;
                    end
                    2'b00: begin
                        if (r_cnt >= L_MIN_MOD) begin
                            w_nxt = S_SETTLE;
                        end else begin
                            w_set_err = 1'b1;
                            w_code    = L_ERR_HOLD;
                        end
                    end
                    default: w_nxt = S_MOD_HOLD;
                endcase
            end
            S_READY: begin
                case (w_cm)
                    2'b11: w_nxt = S_CLK_HOLD;
                    2'b01: w_nxt = S_MOD_HOLD;
                    2'b10: begin
                        w_set_err = 1'b1;
                        w_code    = L_ERR_ORPHAN;
                    end
                    default: w_nxt = S_READY;
                endcase
            end
            S_ERROR: w_nxt = S_ERROR;
            default: begin
                w_set_err = 1'b1;
                w_code    = L_ERR_ORDER;
            end
        endcase
        if (w_set_err) begin
            w_nxt = S_ERROR;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_WAIT_RST;
            r_cnt      <= 8'd0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
        end else begin
            r_state <= w_nxt;
            if (w_nxt != r_state) begin
                r_cnt <= 8'd1;
            end else if (r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'd1;
            end
            r_ready <= (w_nxt == S_READY);
            r_err   <= (w_nxt == S_ERROR);
            // ERROR never sets w_set_err, so the first cause is kept
            if (w_set_err) begin
                r_err_code <= w_code;
            end
        end
    end

`ifdef UART_RST_ACK_STATS_EN
    logic [7:0] r_rst_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rst_cnt <= 8'd0;
        end else if (r_state == S_SETTLE && w_nxt == S_READY && r_rst_cnt != 8'hFF) begin
            r_rst_cnt <= r_rst_cnt + 8'd1;
        end
    end

    assign RST_CNT = r_rst_cnt;
`endif

    assign READY    = r_ready;
    assign ERR      = r_err;
    assign ERR_CODE = r_err_code;
    assign STATE    = r_state;

endmodule

// File: tb/tb_uart_rst_ack.sv
// Scoreboard bench for uart_rst_ack: stimulus queues expected outputs per edge, a negedge monitor pops and compares.
module tb_uart_rst_ack;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CLK_RST = 1'b0;
    logic       MOD_RST = 1'b0;
    logic       READY;
    logic       ERR;
    logic [1:0] ERR_CODE;
    logic [2:0] STATE;
`ifdef UART_RST_ACK_STATS_EN
    logic [7:0] RST_CNT;
`endif

    uart_rst_ack #(.MIN_CLK_HOLD(2), .MIN_MOD_HOLD(200), .SETTLE_CYC(16)) dut (
        .CLK(CLK),
        .RST(RST),
        .CLK_RST(CLK_RST),
        .MOD_RST(MOD_RST),
        .READY(READY),
        .ERR(ERR),
        .ERR_CODE(ERR_CODE),
`ifdef UART_RST_ACK_STATS_EN
        .RST_CNT(RST_CNT),
`endif
        .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       rdy;
        logic       err;
        logic [1:0] code;
        logic [7:0] rc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   edge_n = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s at edge %0d: actual=%0d expected=%0d", name, cyc, act, exp_v);
        end
    endfunction

    always @(negedge CLK) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            if (mon_e.cyc < cyc) begin
                chk("missed_edge", cyc, mon_e.cyc);
            end else begin
                chk("STATE", int'(STATE), int'(mon_e.st));
                chk("READY", int'(READY), int'(mon_e.rdy));
                chk("ERR", int'(ERR), int'(mon_e.err));
                chk("ERR_CODE", int'(ERR_CODE), int'(mon_e.code));
`ifdef UART_RST_ACK_STATS_EN
                chk("RST_CNT", int'(RST_CNT), int'(mon_e.rc));
`endif
            end
        end
    end

    task automatic expect_now(input logic [2:0] st, input logic rdy, input logic err,
                              input logic [1:0] code, input logic [7:0] rc);
        exp_t e;
        e.cyc  = edge_n;
        e.st   = st;
        e.rdy  = rdy;
        e.err  = err;
        e.code = code;
        e.rc   = rc;
        q.push_back(e);
    endtask

    task automatic run(input logic c, input logic m, input int n);
        for (int i = 0; i < n; i++) begin
            CLK_RST = c;
            MOD_RST = m;
            @(posedge CLK);
            edge_n++;
            #1;
        end
    endtask

    task automatic do_rst();
        RST     = 1'b1;
        CLK_RST = 1'b0;
        MOD_RST = 1'b0;
        @(posedge CLK);
        edge_n++;
        #1;
        RST = 1'b0;
        expect_now(3'd0, 1'b0, 1'b0, 2'd0, 8'd0);
    endtask

    // Cold sequence from WAIT_RST ending in READY; rc_before is RST_CNT beforehand
    task automatic nominal(input logic [7:0] rc_before);
        run(1, 1, 1); expect_now(3'd1, 0, 0, 2'd0, rc_before);
        run(1, 1, 1); expect_now(3'd1, 0, 0, 2'd0, rc_before);
        run(0, 1, 1); expect_now(3'd2, 0, 0, 2'd0, rc_before);
        run(0, 1, 253); expect_now(3'd2, 0, 0, 2'd0, rc_before);
        run(0, 0, 1); expect_now(3'd3, 0, 0, 2'd0, rc_before);
        run(0, 0, 14);
        run(0, 0, 1); expect_now(3'd3, 0, 0, 2'd0, rc_before);
        run(0, 0, 1); expect_now(3'd4, 1, 0, 2'd0, rc_before + 8'd1);
    endtask

    initial begin
        do_rst();

        // nominal cold release, READY holds
        nominal(8'd0);
        run(0, 0, 3); expect_now(3'd4, 1, 0, 2'd0, 8'd1);

        // warm module reset from READY
        run(0, 1, 1); expect_now(3'd2, 0, 0, 2'd0, 8'd1);
        run(0, 1, 209); expect_now(3'd2, 0, 0, 2'd0, 8'd1);
        run(0, 0, 1); expect_now(3'd3, 0, 0, 2'd0, 8'd1);
        run(0, 0, 14);
        run(0, 0, 1); expect_now(3'd3, 0, 0, 2'd0, 8'd1);
        run(0, 0, 1); expect_now(3'd4, 1, 0, 2'd0, 8'd2);

        // orphan clock reset from READY; later violations ignored; ERROR keeps RST_CNT
        run(1, 0, 1); expect_now(3'd5, 0, 1, 2'd1, 8'd2);
        run(1, 1, 3); expect_now(3'd5, 0, 1, 2'd1, 8'd2);
        do_rst();

        // RST at SETTLE cnt=8, then a clean sequence
        run(1, 1, 2);
        run(0, 1, 254);
        run(0, 0, 1);
        run(0, 0, 7); expect_now(3'd3, 0, 0, 2'd0, 8'd0);
        do_rst();
        nominal(8'd0);
        do_rst();

        // short module hold, sticky for 50 cycles
        run(1, 1, 2);
        run(0, 1, 100);
        run(0, 0, 1); expect_now(3'd5, 0, 1, 2'd2, 8'd0);
        run(0, 0, 49); expect_now(3'd5, 0, 1, 2'd2, 8'd0);
        run(1, 0, 1); expect_now(3'd5, 0, 1, 2'd2, 8'd0);
        do_rst();

        // orphan clock reset from WAIT_RST
        run(1, 0, 1); expect_now(3'd5, 0, 1, 2'd1, 8'd0);
        do_rst();

        // both drop together from CLK_HOLD
        run(1, 1, 5);
        run(0, 0, 1); expect_now(3'd5, 0, 1, 2'd3, 8'd0);
        do_rst();

        // MOD_RST drops with CLK_RST still high: order, not orphan
        run(1, 1, 3);
        run(1, 0, 1); expect_now(3'd5, 0, 1, 2'd3, 8'd0);
        do_rst();

        // common hold one short
        run(1, 1, 1);
        run(0, 1, 1); expect_now(3'd5, 0, 1, 2'd2, 8'd0);
        do_rst();

        // module hold boundary: 199 fails, 200 passes
        run(1, 1, 2);
        run(0, 1, 199);
        run(0, 0, 1); expect_now(3'd5, 0, 1, 2'd2, 8'd0);
        do_rst();
        run(1, 1, 2);
        run(0, 1, 200);
        run(0, 0, 1); expect_now(3'd3, 0, 0, 2'd0, 8'd0);
        do_rst();

        // sequence restart from MOD_HOLD
        run(1, 1, 2);
        run(0, 1, 5);
        run(1, 1, 1); expect_now(3'd1, 0, 0, 2'd0, 8'd0);
        do_rst();

        run(0, 0, 3);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
